// File: rtl/bloom_pkg.sv
// Shared types and default sizing for the bloom filter controller.
package bloom_pkg;

  localparam int unsigned BL_SIZE_DEF   = 256;
  localparam int unsigned HASH_SIZE_DEF = 8;
  localparam int unsigned NUM_HASH_DEF  = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INSERT = 2'd1,
    ST_QUERY  = 2'd2,
    ST_RESP   = 2'd3
  } state_e;

endpackage

// File: rtl/bloom_rr_arb.sv
// Two-way round-robin arbiter (req[0] = insert, req[1] = query).
// gnt[i] means "requester i is not blocked by the other", so a grant never depends on its own req.
module bloom_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       adv,
  output logic [1:0] gnt
);

  logic last_qry_q;
  logic last_qry_d;

  always_comb begin
    gnt[0] = ~req[1] | last_qry_q;
    gnt[1] = ~req[0] | ~last_qry_q;
  end

  // On a handshake the query side won only if it was both requesting and unblocked.
  always_comb begin
    last_qry_d = last_qry_q;
    if (adv) begin
      last_qry_d = req[1] & gnt[1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_qry_q <= 1'b1;
    end else begin
      last_qry_q <= last_qry_d;
    end
  end

endmodule

// File: rtl/bloom_ctrl.sv
// Bloom filter controller: serial K-step insert/query over a register-held bit vector,
// with round-robin arbitration and deferred clear.
module bloom_ctrl
  import bloom_pkg::*;
#(
  parameter int unsigned BL_SIZE   = BL_SIZE_DEF,
  parameter int unsigned HASH_SIZE = HASH_SIZE_DEF,
  parameter int unsigned NUM_HASH  = NUM_HASH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          ins_valid,
  output logic                          ins_ready,
  input  logic [NUM_HASH*HASH_SIZE-1:0] ins_hashes,
  input  logic                          q_valid,
  output logic                          q_ready,
  input  logic [NUM_HASH*HASH_SIZE-1:0] q_hashes,
  output logic                          resp_valid,
  output logic                          resp_hit,
  output logic                          ins_done,
  output logic                          busy,
  output logic [BL_SIZE-1:0]            bloom_o
);

  localparam int unsigned SW = $clog2(NUM_HASH + 1);
  localparam int unsigned IW = (NUM_HASH > 1) ? $clog2(NUM_HASH) : 1;
  localparam int unsigned BW = (BL_SIZE > 1) ? $clog2(BL_SIZE) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(NUM_HASH - 1);

  typedef logic [NUM_HASH-1:0][HASH_SIZE-1:0] idx_vec_t;

  state_e             state_q, state_d;
  logic [SW-1:0]      step_q, step_d;
  idx_vec_t           idx_q, idx_d;
  logic [BL_SIZE-1:0] bloom_q, bloom_d;
  logic               clr_pend_q, clr_pend_d;
  logic               ins_done_q, ins_done_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_hit_q, resp_hit_d;
  logic               busy_q, busy_d;

  logic [1:0]           arb_gnt;
  logic                 arb_adv;
  logic                 idle_free;
  logic                 ins_acc;
  logic                 q_acc;
  logic [HASH_SIZE-1:0] cur_idx;
  logic [BW-1:0]        cur_bit;
  logic                 cur_in_range;

  bloom_rr_arb u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req   ({q_valid, ins_valid}),
    .adv   (arb_adv),
    .gnt   (arb_gnt)
  );

  // Grants only from a quiet IDLE: a live or pending clear takes the cycle instead.
  assign idle_free = (state_q == ST_IDLE) & ~clr_pend_q & ~clear;
  assign ins_ready = rst_n & idle_free & arb_gnt[0];
  assign q_ready   = rst_n & idle_free & arb_gnt[1];
  assign ins_acc   = ins_valid & ins_ready;
  assign q_acc     = q_valid & q_ready;
  assign arb_adv   = ins_acc | q_acc;

  assign cur_idx      = idx_q[IW'(step_q)];
  assign cur_bit      = BW'(cur_idx);
  assign cur_in_range = (32'(cur_idx) < 32'(BL_SIZE));

  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    idx_d        = idx_q;
    bloom_d      = bloom_q;
    clr_pend_d   = clr_pend_q;
    ins_done_d   = 1'b0;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;

    unique case (state_q)
      ST_IDLE: begin
        if (clear || clr_pend_q) begin
          bloom_d    = '0;
          clr_pend_d = 1'b0;
        end else if (ins_acc) begin
          idx_d      = ins_hashes;
          step_d     = '0;
          state_d    = ST_INSERT;
          ins_done_d = (NUM_HASH == 1);
        end else if (q_acc) begin
          idx_d   = q_hashes;
          step_d  = '0;
          state_d = ST_QUERY;
        end
      end

      // ins_done is raised during the last write step.
      ST_INSERT: begin
        clr_pend_d = clr_pend_q | clear;
        if (cur_in_range) begin
          bloom_d[cur_bit] = 1'b1;
        end
        if (step_q == LAST_STEP) begin
          state_d = ST_IDLE;
          step_d  = '0;
        end else begin
          step_d     = step_q + SW'(1);
          ins_done_d = (step_d == LAST_STEP);
        end
      end

      ST_QUERY: begin
        clr_pend_d = clr_pend_q | clear;
        if (!(cur_in_range && bloom_q[cur_bit])) begin
          resp_hit_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
          step_d       = '0;
        end else if (step_q == LAST_STEP) begin
          resp_hit_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = ST_RESP;
          step_d       = '0;
        end else begin
          step_d = step_q + SW'(1);
        end
      end

      ST_RESP: begin
        clr_pend_d = clr_pend_q | clear;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      step_q       <= '0;
      idx_q        <= '0;
      bloom_q      <= '0;
      clr_pend_q   <= 1'b0;
      ins_done_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      step_q       <= step_d;
      idx_q        <= idx_d;
      bloom_q      <= bloom_d;
      clr_pend_q   <= clr_pend_d;
      ins_done_q   <= ins_done_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      busy_q       <= busy_d;
    end
  end

  assign bloom_o    = bloom_q;
  assign ins_done   = ins_done_q;
  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_bloom_ctrl.sv
// Self-checking bench for bloom_ctrl: directed scenarios plus random insert/query traffic
// checked against an array-based bloom model and cycle timing derived from the request rules.
`timescale 1ns/1ps
module tb_bloom_ctrl;

  localparam int BL  = 256;
  localparam int HS  = 8;
  localparam int K   = 3;
  localparam int HS9 = 9;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic clear = 1'b0;
  logic ins_valid = 1'b0;
  logic q_valid   = 1'b0;
  logic [K*HS-1:0] ins_hashes = '0;
  logic [K*HS-1:0] q_hashes   = '0;
  logic ins_ready, q_ready, resp_valid, resp_hit, ins_done, busy;
  logic [BL-1:0] bloom_o;

  logic clear9 = 1'b0;
  logic ins_valid9 = 1'b0;
  logic q_valid9   = 1'b0;
  logic [K*HS9-1:0] ins_hashes9 = '0;
  logic [K*HS9-1:0] q_hashes9   = '0;
  logic ins_ready9, q_ready9, resp_valid9, resp_hit9, ins_done9, busy9;
  logic [BL-1:0] bloom9;

  int errors = 0;
  int checks = 0;
  bit model [BL];
  bit model_last_q = 1'b1;

  bloom_ctrl #(.BL_SIZE(BL), .HASH_SIZE(HS), .NUM_HASH(K)) u_dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_hashes(ins_hashes),
    .q_valid(q_valid), .q_ready(q_ready), .q_hashes(q_hashes),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .ins_done(ins_done),
    .busy(busy), .bloom_o(bloom_o)
  );

  bloom_ctrl #(.BL_SIZE(BL), .HASH_SIZE(HS9), .NUM_HASH(K)) u_dut9 (
    .clk(clk), .rst_n(rst_n), .clear(clear9),
    .ins_valid(ins_valid9), .ins_ready(ins_ready9), .ins_hashes(ins_hashes9),
    .q_valid(q_valid9), .q_ready(q_ready9), .q_hashes(q_hashes9),
    .resp_valid(resp_valid9), .resp_hit(resp_hit9), .ins_done(ins_done9),
    .busy(busy9), .bloom_o(bloom9)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [BL-1:0] obs, input logic [BL-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BL-1:0] model_vec();
    logic [BL-1:0] v;
    v = '0;
    for (int b = 0; b < BL; b++) v[b] = model[b];
    return v;
  endfunction

  function automatic logic [K*HS-1:0] pack3(input int a, input int b, input int c);
    return {8'(c), 8'(b), 8'(a)};
  endfunction

  task automatic model_clear();
    for (int b = 0; b < BL; b++) model[b] = 1'b0;
  endtask

  // One request; clr_at / rst_at (cycle number after the accept edge, 0 = never) inject clear or reset.
  task automatic run_op(input string tag, input bit is_ins, input int i0, input int i1, input int i2,
                        input int clr_at, input int rst_at);
    int idx [3];
    int exp_c;
    bit exp_hit;
    int ev_c;
    int pulses;
    bit ev_hit;
    int n;
    bit acc;
    idx[0] = i0; idx[1] = i1; idx[2] = i2;
    exp_hit = 1'b1;
    exp_c   = is_ins ? K : K + 1;
    if (!is_ins) begin
      for (int j = 0; j < K; j++) begin
        if (exp_hit && (idx[j] >= BL || !model[idx[j]])) begin
          exp_hit = 1'b0;
          exp_c   = j + 2;
        end
      end
    end

    @(posedge clk); #1;
    if (is_ins) begin ins_valid = 1'b1; ins_hashes = pack3(i0, i1, i2); end
    else        begin q_valid   = 1'b1; q_hashes   = pack3(i0, i1, i2); end
    n = 0;
    @(negedge clk);
    while (!(is_ins ? ins_ready : q_ready) && n < 40) begin
      @(negedge clk);
      n++;
    end
    acc = is_ins ? ins_ready : q_ready;
    check({tag, "_accept"}, acc, 1'b1);
    @(posedge clk); #1;
    ins_valid = 1'b0;
    q_valid   = 1'b0;
    if (!acc) return;
    model_last_q = !is_ins;

    ev_c = 0; pulses = 0; ev_hit = 1'b0;
    for (int c = 1; c <= K + 3; c++) begin
      @(negedge clk);
      if (ins_done || resp_valid) begin
        pulses++;
        if (ev_c == 0) begin ev_c = c; ev_hit = resp_hit; end
      end
      clear = (c == clr_at);
      if (c == rst_at) begin
        rst_n = 1'b0; ins_valid = 1'b1; q_valid = 1'b1;
        #1;
        check({tag, "_rst_ready"}, {ins_ready, q_ready}, 2'b00);
        check({tag, "_rst_flags"}, {busy, resp_valid, resp_hit, ins_done}, 4'b0000);
        check({tag, "_rst_bloom"}, bloom_o, '0);
        ins_valid = 1'b0; q_valid = 1'b0;
      end
    end
    clear = 1'b0;

    if (rst_at > 0) begin
      check({tag, "_rst_no_pulse"}, pulses, 0);
      rst_n = 1'b1;
      model_clear();
      model_last_q = 1'b1;
      return;
    end

    check({tag, "_event_cycle"}, ev_c, exp_c);
    check({tag, "_pulses"}, pulses, 1);
    if (!is_ins) check({tag, "_hit"}, ev_hit, exp_hit);
    if (is_ins) begin
      for (int j = 0; j < K; j++) if (idx[j] < BL) model[idx[j]] = 1'b1;
    end
    if (clr_at > 0) model_clear();
    check({tag, "_bloom"}, bloom_o, model_vec());
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  // Clear in IDLE with an insert waiting: nothing is granted and the vector empties.
  task automatic clear_idle(input string tag);
    @(posedge clk); #1;
    clear = 1'b1; ins_valid = 1'b1; ins_hashes = pack3(7, 8, 9);
    #1;
    check({tag, "_no_grant"}, ins_ready, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0; ins_valid = 1'b0;
    model_clear();
    @(negedge clk);
    check({tag, "_zeroed"}, bloom_o, model_vec());
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  initial begin
    logic [BL-1:0] exp9;
    int list9 [3];
    int n;
    int ev_c;
    bit ev_hit;
    bit got_q;

    model_clear();
    ins_valid = 1'b1; q_valid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", {ins_ready, q_ready}, 2'b00);
    check("rst_bloom", bloom_o, '0);
    check("rst_flags", {busy, resp_valid, resp_hit, ins_done}, 4'b0000);
    ins_valid = 1'b0; q_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);

    run_op("ins_5_17_200", 1'b1, 5, 17, 200, 0, 0);
    check("bits_5_17_200", {bloom_o[200], bloom_o[17], bloom_o[5]}, 3'b111);
    run_op("q_5_17_200", 1'b0, 5, 17, 200, 0, 0);
    run_op("q_5_9_200", 1'b0, 5, 9, 200, 0, 0);

    // Both requesters held high: grants follow round-robin starting from the model's last grant.
    ins_hashes = pack3(10, 11, 12);
    q_hashes   = pack3(10, 11, 12);
    @(posedge clk); #1;
    ins_valid = 1'b1; q_valid = 1'b1;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      n = 0;
      while (!(ins_ready || q_ready) && n < 40) begin
        @(negedge clk);
        n++;
      end
      check($sformatf("rr_grant%0d", g), {ins_ready, q_ready}, model_last_q ? 2'b10 : 2'b01);
      got_q = q_ready;
      if (ins_ready && !got_q) begin
        model[10] = 1'b1; model[11] = 1'b1; model[12] = 1'b1;
      end
      model_last_q = got_q;
      @(posedge clk); #1;
    end
    ins_valid = 1'b0; q_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("rr_bloom", bloom_o, model_vec());

    run_op("ins_clr_1_2_3", 1'b1, 1, 2, 3, 1, 0);
    run_op("q_after_clr", 1'b0, 1, 2, 3, 0, 0);

    run_op("ins_pre_idle_clr", 1'b1, 20, 21, 22, 0, 0);
    clear_idle("idle_clr");
    run_op("q_after_idle_clr", 1'b0, 20, 21, 22, 0, 0);

    for (int r = 0; r < 24; r++) begin
      if ($urandom_range(0, 9) == 0) clear_idle($sformatf("rnd%0d_clr", r));
      run_op($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)),
             int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), int'($urandom_range(0, 40)), 0, 0);
    end

    run_op("ins_pre_rst", 1'b1, 5, 9, 10, 0, 0);
    run_op("q_rst_mid", 1'b0, 5, 9, 10, 0, 2);
    @(negedge clk);
    check("post_rst_bloom", bloom_o, '0);
    run_op("ins_post_rst", 1'b1, 30, 31, 32, 0, 0);
    run_op("q_post_rst", 1'b0, 30, 31, 32, 0, 0);

    // 9-bit indices on a 256-bit vector: 300 is out of range.
    list9[0] = 300; list9[1] = 4; list9[2] = 4;
    exp9 = '0;
    for (int j = 0; j < K; j++) if (list9[j] < BL) exp9[list9[j]] = 1'b1;
    @(posedge clk); #1;
    ins_hashes9 = {9'd4, 9'd4, 9'd300};
    ins_valid9  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!ins_ready9 && n < 40) begin @(negedge clk); n++; end
    check("h9_ins_accept", ins_ready9, 1'b1);
    @(posedge clk); #1;
    ins_valid9 = 1'b0;
    repeat (5) @(negedge clk);
    check("h9_bloom", bloom9, exp9);

    q_hashes9 = {9'd4, 9'd4, 9'd300};
    q_valid9  = 1'b1;
    n = 0;
    @(negedge clk);
    while (!q_ready9 && n < 40) begin @(negedge clk); n++; end
    check("h9_q_accept", q_ready9, 1'b1);
    @(posedge clk); #1;
    q_valid9 = 1'b0;
    ev_c = 0; ev_hit = 1'b1;
    for (int c = 1; c <= K + 3; c++) begin
      @(negedge clk);
      if (resp_valid9 && ev_c == 0) begin ev_c = c; ev_hit = resp_hit9; end
    end
    check("h9_resp_cycle", ev_c, 2);
    check("h9_resp_hit", ev_hit, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bloom_ctrl.md
BLOOM_CTRL -- requirements
Module: bloom_ctrl

Interface
REQ-001 SHALL have parameter BL_SIZE, default 256, giving the bloom vector width in bits.
REQ-002 SHALL have parameter HASH_SIZE, default 8, giving the bit width of one hash index.
REQ-003 SHALL have parameter NUM_HASH, default 3, giving the number of hash indices per request (K).
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port clear  in  1  request to zero the bloom vector.
REQ-007 SHALL have port ins_valid  in  1  insert request valid.
REQ-008 SHALL have port ins_ready  out  1  insert request accepted when high with ins_valid.
REQ-009 SHALL have port ins_hashes  in  NUM_HASH*HASH_SIZE  packed insert indices; index i is bits [i*HASH_SIZE +: HASH_SIZE].
REQ-010 SHALL have port q_valid  in  1  query request valid.
REQ-011 SHALL have port q_ready  out  1  query request accepted when high with q_valid.
REQ-012 SHALL have port q_hashes  in  NUM_HASH*HASH_SIZE  packed query indices, same packing as ins_hashes.
REQ-013 SHALL have port resp_valid  out  1  one-cycle pulse carrying a query result.
REQ-014 SHALL have port resp_hit  out  1  query result; meaningful only while resp_valid is high.
REQ-015 SHALL have port ins_done  out  1  one-cycle pulse on insert completion.
REQ-016 SHALL have port busy  out  1  high in every state other than IDLE.
REQ-017 SHALL have port bloom_o  out  BL_SIZE  current bloom vector, driven directly from a register.

Function
REQ-018 SHALL implement the states IDLE, INSERT, QUERY and RESP.
REQ-019 SHALL drive ins_ready and q_ready only in IDLE with no clear pending; they SHALL depend only on state, pending clear and arbitration, never on their own valid.
REQ-020 SHALL grant round-robin when both valids are high in IDLE; the winner is the requester not granted last, and last-grant resets to query so insert wins the first tie.
REQ-021 SHALL latch the K indices of the granted request on the accept edge T, zero the step counter, and enter INSERT or QUERY.
REQ-022 INSERT SHALL set bloom[idx[i]] in cycle T+1+i for i = 0..K-1, assert ins_done in cycle T+K, and return to IDLE after that cycle.
REQ-023 QUERY SHALL test bloom[idx[i]] in cycle T+1+i; the first zero bit SHALL end the test with hit=0, and K ones SHALL give hit=1.
REQ-024 RESP SHALL assert resp_valid for exactly one cycle with resp_hit held stable, then return to IDLE; a full hit responds in cycle T+K+1 and a miss at step j responds in cycle T+j+2.
REQ-025 SHALL have no downstream backpressure; a response is not held or repeated.
REQ-026 SHALL treat an index >= BL_SIZE as out of range: an insert step writes nothing, and a query step counts as a miss.
REQ-027 SHALL, when clear is high in IDLE, zero bloom_o on the next edge and grant no request in that cycle.
REQ-028 SHALL, when clear is high outside IDLE, set a pending flag; the clear is applied in the first IDLE cycle, before any grant, and the in-flight operation completes unaffected.
REQ-029 A duplicate index within one insert SHALL be harmless: the bit is set once and no error is raised.
REQ-030 SHALL use a step counter of $clog2(NUM_HASH+1) bits that never wraps within an operation.

Reset
REQ-031 SHALL, on assertion of rst_n, immediately clear: state to IDLE, bloom_o, ins_done, resp_valid, resp_hit, the pending clear, the step counter and the latched indices to 0, and last-grant to query.
REQ-032 SHALL abandon an operation cut by reset mid-flight without issuing a response or done pulse, and SHALL keep no partial insert.
REQ-033 ins_ready and q_ready SHALL be 0 while rst_n is low.

Structure
REQ-034 Package bloom_pkg SHALL hold the state enum and the default parameter constants.
REQ-035 The round-robin grant SHALL be a sub-module bloom_rr_arb with inputs req[1:0] and adv, and output gnt[1:0].
REQ-036 The bloom vector, step counter and FSM SHALL live in bloom_ctrl; the design SHALL contain no memories and no latches.

Verification (BL_SIZE=256, HASH_SIZE=8, NUM_HASH=3)
REQ-037 Insert {5,17,200}, then query {5,17,200} -> ins_done at T+3; bits 5, 17 and 200 set; resp_valid with hit=1 at T'+4.
REQ-038 After REQ-037, query {5,9,200} -> resp_valid with hit=0 at T'+3 (early exit at step 1).
REQ-039 ins_valid and q_valid held high together for 4 operations -> grants alternate insert, query, insert, query.
REQ-040 Clear pulsed during an insert {1,2,3} -> the insert completes with ins_done, then bloom_o becomes 0 before the next grant and a query {1,2,3} returns hit=0.
REQ-041 With HASH_SIZE=9, insert {300,4,4} -> only bit 4 set; query {300,4,4} -> hit=0 at step 0.
REQ-042 rst_n asserted in cycle T+2 of a query -> no resp_valid, all outputs 0, and normal operation resumes after release.
